ifu_fetch_ctrl: RTL and testbench
=================================

// Module: ifu_fetch_ctrl
// PURPOSE
//  Instruction-fetch request stage of the IFU. Owns the architectural fetch PC register, feeds pc and
//  inst_rdata_1_ok/inst_rdata_2_ok to the next-PC mux, and loads the mux's next_pc result.
//  Issues 8-byte-aligned requests on the SRAM-like instruction bus and delivers up to two words per
//  cycle to the decode queue. Keeps one request in flight, has a one-entry hold buffer for decode
//  stalls, and cancels in-flight responses on a redirect.
// PARAMETERS
//  RESET_PC  32'hBFC0_0000  fetch PC loaded on reset
// PORTS
//  clk              in   1   clock; all state updates on posedge
//  rst              in   1   synchronous active-high reset
//  next_pc          in   32  next-PC mux result
//  redirect         in   1   flush_req | exception_pc_ena; next_pc holds the redirect target
//  stall            in   1   decode queue cannot accept this cycle
//  pc               out  32  fetch PC register, fed back to the next-PC mux
//  inst_rdata_1_ok  out  1   word 1 delivered this cycle
//  inst_rdata_2_ok  out  1   word 2 delivered this cycle; only with inst_rdata_1_ok
//  inst_rdata_1     out  32  instruction at pc
//  inst_rdata_2     out  32  instruction at pc+4
//  inst_req         out  1   bus request
//  inst_addr        out  32  {pc[31:3],3'b000}
//  inst_addr_ok     in   1   request accepted this cycle
//  inst_data_ok     in   1   response valid this cycle, in request order
//  inst_rdata       in   64  [31:0] = word at addr, [63:32] = word at addr+4
// BEHAVIOUR
//  States: IDLE, REQ (inst_req=1, waiting addr_ok), WAIT (waiting data_ok), HOLD (buffer full),
//   CANCEL (draining one stale response). Reset: state=IDLE, pc=RESET_PC, all outputs 0.
//  Word select: pc[2]=0 gives rdata_1=rdata[31:0], rdata_2=rdata[63:32], two words.
//   pc[2]=1 gives rdata_1=rdata[63:32], rdata_2_ok=0, one word.
//  Delivery cycle: inst_rdata_*_ok asserted combinationally. It occurs when (WAIT & data_ok & !stall
//   & !redirect) or (HOLD & !stall & !redirect). pc <= next_pc on every delivery cycle.
//  IDLE -> REQ unconditionally (one idle cycle after reset).
//  REQ: addr_ok -> WAIT. With no addr_ok, stay in REQ. inst_addr tracks pc; the bus permits
//   retargeting before addr_ok.
//  WAIT + data_ok: stall=0 delivers and goes to REQ. stall=1 captures both words in the hold buffer
//   and goes to HOLD.
//  HOLD: no bus request. Delivers from the buffer when stall=0, then goes to REQ.
//  CANCEL: no request and no delivery. data_ok discards the response and goes to REQ.
//  Redirect (top priority):
//   - pc <= next_pc in every state.
//   - No delivery that cycle (both ok=0).
//   - REQ without addr_ok: stay in REQ.
//   - REQ with addr_ok: go to CANCEL.
//   - WAIT without data_ok: go to CANCEL.
//   - WAIT with data_ok: drop the response, go to REQ.
//   - HOLD: clear the buffer, go to REQ.
//   - CANCEL: stay in CANCEL.
//  Only one transaction is ever outstanding, so at most one stale response exists.
//  pc wraps modulo 2^32 (next_pc is computed upstream). pc changes only on delivery or redirect.
//  rst mid-transaction returns to IDLE. A response arriving afterwards is a bus-side reset concern.
// TESTING
//  1. Reset, addr_ok=1 in REQ, data_ok=1 the next cycle, pc=BFC00000. Required response: inst_addr=
//     BFC00000, both ok=1, rdata_1=rdata[31:0]; with next_pc=BFC00008, pc=BFC00008 one cycle later.
//  2. pc=BFC00004 delivered. Required response: rdata_1=rdata[63:32], rdata_2_ok=0; next_pc=BFC00008 loaded.
//  3. WAIT, data_ok with stall=1, stall held 3 cycles. Required response: HOLD with inst_req=0, no ok
//     pulses; delivers the same data and pc on the cycle stall drops.
//  4. Redirect to 80000180 in WAIT with no data_ok, then data_ok two cycles later. Required response:
//     CANCEL, stale data never delivered; next request has inst_addr=80000180.
//  5. Redirect in the same cycle as data_ok. Required response: no delivery, pc=target, next state
//     REQ; redirect with addr_ok in REQ goes to CANCEL.
//  6. rst asserted in HOLD and in CANCEL. Required response: next cycle IDLE, pc=RESET_PC, all outputs 0.

Source files
------------

// File: rtl/ifu_fetch_ctrl.sv
// IFU fetch request stage: owns the fetch PC and issues one 8-byte-aligned request at a time.
// It delivers one or two instruction words, holds them in a buffer while decode stalls, and drops a stale response after a redirect.
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  input  logic        stall,
  output logic [31:0] pc,
  output logic        inst_rdata_1_ok,
  output logic        inst_rdata_2_ok,
  output logic [31:0] inst_rdata_1,
  output logic [31:0] inst_rdata_2,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [63:0] inst_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    HOLD   = 3'd3,
    CANCEL = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [63:0] buf_q, buf_d;
  logic        deliver;
  logic [63:0] src;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    deliver = 1'b0;
    src     = inst_rdata;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (inst_addr_ok) state_d = redirect ? CANCEL : WAIT;
      end
      WAIT: begin
        if (inst_data_ok) begin
          if (redirect) begin
            state_d = REQ;
          end else if (stall) begin
            buf_d   = inst_rdata;
            state_d = HOLD;
          end else begin
            deliver = 1'b1;
            state_d = REQ;
          end
        end else if (redirect) begin
          state_d = CANCEL;
        end
      end
      HOLD: begin
        src = buf_q;
        if (redirect) begin
          buf_d   = '0;
          state_d = REQ;
        end else if (!stall) begin
          deliver = 1'b1;
          state_d = REQ;
        end
      end
      CANCEL: begin
        // The stale response is drained even if a redirect lands in the same cycle.
        // Otherwise the FSM would wait for a response that never arrives.
        if (inst_data_ok) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d = (redirect || deliver) ? next_pc : pc_q;
  end

  always_comb begin
    inst_rdata_1_ok = 1'b0;
    inst_rdata_2_ok = 1'b0;
    inst_rdata_1    = '0;
    inst_rdata_2    = '0;
    if (deliver) begin
      inst_rdata_1_ok = 1'b1;
      if (pc_q[2]) begin
        inst_rdata_1 = src[63:32];
      end else begin
        inst_rdata_2_ok = 1'b1;
        inst_rdata_1    = src[31:0];
        inst_rdata_2    = src[63:32];
      end
    end
  end

  assign pc        = pc_q;
  assign inst_req  = (state_q == REQ);
  assign inst_addr = {pc_q[31:3], 3'b000};

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed self-checking bench for ifu_fetch_ctrl.
// It drives inputs 1ns after each rising edge and samples outputs 1ns later.
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;
  logic        redirect;
  logic        stall;
  logic [31:0] pc;
  logic        inst_rdata_1_ok, inst_rdata_2_ok;
  logic [31:0] inst_rdata_1, inst_rdata_2;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [63:0] inst_rdata;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ifu_fetch_ctrl #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk(clk), .rst(rst), .next_pc(next_pc), .redirect(redirect), .stall(stall),
    .pc(pc), .inst_rdata_1_ok(inst_rdata_1_ok), .inst_rdata_2_ok(inst_rdata_2_ok),
    .inst_rdata_1(inst_rdata_1), .inst_rdata_2(inst_rdata_2), .inst_req(inst_req),
    .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    rst = 1'b0; redirect = 1'b0; stall = 1'b0; next_pc = '0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
  endtask

  // Advance one clock, clear the inputs, then let the outputs settle.
  task automatic tick();
    @(posedge clk); #1;
    clear_inputs();
    #1;
  endtask

  task automatic test_reset();
    clear_inputs(); rst = 1'b1;
    tick(); rst = 1'b1; tick(); rst = 1'b1; #1;
    checks++;
    if (pc !== 32'hBFC0_0000) begin errors++; $display("FAIL reset_pc got %h want bfc00000", pc); end
    checks++;
    if ({inst_req, inst_rdata_1_ok, inst_rdata_2_ok, inst_rdata_1, inst_rdata_2} !== 67'd0) begin
      errors++; $display("FAIL reset_outputs got req=%b ok=%b%b d1=%h d2=%h want all 0",
        inst_req, inst_rdata_1_ok, inst_rdata_2_ok, inst_rdata_1, inst_rdata_2);
    end
    tick();
    checks++;
    if (inst_req !== 1'b0) begin errors++; $display("FAIL idle_req got %b want 0", inst_req); end
    tick();
  endtask

  task automatic test_two_word();
    checks++;
    if ({inst_req, inst_addr} !== {1'b1, 32'hBFC0_0000}) begin
      errors++; $display("FAIL req_first got req=%b addr=%h want 1 bfc00000", inst_req, inst_addr);
    end
    inst_addr_ok = 1'b1; tick();
    inst_data_ok = 1'b1; inst_rdata = 64'h2222_2222_1111_1111; next_pc = 32'hBFC0_0008; #1;
    checks++;
    if ({inst_rdata_1_ok, inst_rdata_2_ok, inst_rdata_1, inst_rdata_2} !== {2'b11, 32'h1111_1111, 32'h2222_2222}) begin
      errors++; $display("FAIL two_word got ok=%b%b d1=%h d2=%h want 11 11111111 22222222",
        inst_rdata_1_ok, inst_rdata_2_ok, inst_rdata_1, inst_rdata_2);
    end
    tick();
    checks++;
    if ({pc, inst_req, inst_addr} !== {32'hBFC0_0008, 1'b1, 32'hBFC0_0008}) begin
      errors++; $display("FAIL two_word_pc got pc=%h req=%b addr=%h want bfc00008 1 bfc00008", pc, inst_req, inst_addr);
    end
  endtask

  task automatic test_one_word();
    redirect = 1'b1; next_pc = 32'hBFC0_0004; tick();
    checks++;
    if ({pc, inst_req, inst_addr} !== {32'hBFC0_0004, 1'b1, 32'hBFC0_0000}) begin
      errors++; $display("FAIL retarget got pc=%h req=%b addr=%h want bfc00004 1 bfc00000", pc, inst_req, inst_addr);
    end
    inst_addr_ok = 1'b1; tick();
    inst_data_ok = 1'b1; inst_rdata = 64'hBBBB_BBBB_AAAA_AAAA; next_pc = 32'hBFC0_0008; #1;
    checks++;
    if ({inst_rdata_1_ok, inst_rdata_2_ok, inst_rdata_1} !== {2'b10, 32'hBBBB_BBBB}) begin
      errors++; $display("FAIL one_word got ok=%b%b d1=%h want 10 bbbbbbbb", inst_rdata_1_ok, inst_rdata_2_ok, inst_rdata_1);
    end
    tick();
    checks++;
    if (pc !== 32'hBFC0_0008) begin errors++; $display("FAIL one_word_pc got %h want bfc00008", pc); end
  endtask

  task automatic test_hold();
    inst_addr_ok = 1'b1; tick();
    inst_data_ok = 1'b1; stall = 1'b1; inst_rdata = 64'h4444_4444_3333_3333; next_pc = 32'hDEAD_0000; #1;
    checks++;
    if ({inst_rdata_1_ok, inst_rdata_2_ok} !== 2'b00) begin
      errors++; $display("FAIL hold_capture ok got %b%b want 00", inst_rdata_1_ok, inst_rdata_2_ok);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      stall = 1'b1; inst_rdata = 64'hFFFF_FFFF_EEEE_EEEE; next_pc = 32'hDEAD_0000; #1;
      checks++;
      if ({inst_req, inst_rdata_1_ok, inst_rdata_2_ok, pc} !== {3'b000, 32'hBFC0_0008}) begin
        errors++; $display("FAIL hold_stall%0d got req=%b ok=%b%b pc=%h want 000 bfc00008",
          i, inst_req, inst_rdata_1_ok, inst_rdata_2_ok, pc);
      end
      tick();
    end
    inst_rdata = 64'hFFFF_FFFF_EEEE_EEEE; next_pc = 32'hBFC0_0010; #1;
    checks++;
    if ({inst_rdata_1_ok, inst_rdata_2_ok, inst_rdata_1, inst_rdata_2, pc} !==
        {2'b11, 32'h3333_3333, 32'h4444_4444, 32'hBFC0_0008}) begin
      errors++; $display("FAIL hold_release got ok=%b%b d1=%h d2=%h pc=%h want 11 33333333 44444444 bfc00008",
        inst_rdata_1_ok, inst_rdata_2_ok, inst_rdata_1, inst_rdata_2, pc);
    end
    tick();
    checks++;
    if ({pc, inst_req} !== {32'hBFC0_0010, 1'b1}) begin
      errors++; $display("FAIL hold_after got pc=%h req=%b want bfc00010 1", pc, inst_req);
    end
  endtask

  task automatic test_cancel();
    inst_addr_ok = 1'b1; tick();
    redirect = 1'b1; next_pc = 32'h8000_0180; #1;
    checks++;
    if ({inst_rdata_1_ok, inst_rdata_2_ok} !== 2'b00) begin
      errors++; $display("FAIL cancel_redir ok got %b%b want 00", inst_rdata_1_ok, inst_rdata_2_ok);
    end
    tick();
    checks++;
    if ({inst_req, pc} !== {1'b0, 32'h8000_0180}) begin
      errors++; $display("FAIL cancel_state got req=%b pc=%h want 0 80000180", inst_req, pc);
    end
    tick();
    inst_data_ok = 1'b1; inst_rdata = 64'h5555_5555_6666_6666; next_pc = 32'h1234_5678; #1;
    checks++;
    if ({inst_req, inst_rdata_1_ok, inst_rdata_2_ok} !== 3'b000) begin
      errors++; $display("FAIL cancel_stale got req=%b ok=%b%b want 000", inst_req, inst_rdata_1_ok, inst_rdata_2_ok);
    end
    tick();
    checks++;
    if ({inst_req, inst_addr, pc} !== {1'b1, 32'h8000_0180, 32'h8000_0180}) begin
      errors++; $display("FAIL cancel_reissue got req=%b addr=%h pc=%h want 1 80000180 80000180", inst_req, inst_addr, pc);
    end
  endtask

  task automatic test_redirect_collide();
    inst_addr_ok = 1'b1; tick();
    inst_data_ok = 1'b1; redirect = 1'b1; next_pc = 32'h8000_0200; inst_rdata = 64'h7777_7777_8888_8888; #1;
    checks++;
    if ({inst_rdata_1_ok, inst_rdata_2_ok} !== 2'b00) begin
      errors++; $display("FAIL collide_ok got %b%b want 00", inst_rdata_1_ok, inst_rdata_2_ok);
    end
    tick();
    checks++;
    if ({inst_req, inst_addr, pc} !== {1'b1, 32'h8000_0200, 32'h8000_0200}) begin
      errors++; $display("FAIL collide_req got req=%b addr=%h pc=%h want 1 80000200 80000200", inst_req, inst_addr, pc);
    end
    inst_addr_ok = 1'b1; redirect = 1'b1; next_pc = 32'h8000_0300; tick();
    checks++;
    if ({inst_req, pc} !== {1'b0, 32'h8000_0300}) begin
      errors++; $display("FAIL req_redir_cancel got req=%b pc=%h want 0 80000300", inst_req, pc);
    end
    inst_data_ok = 1'b1; tick();
    checks++;
    if ({inst_req, inst_addr} !== {1'b1, 32'h8000_0300}) begin
      errors++; $display("FAIL req_redir_reissue got req=%b addr=%h want 1 80000300", inst_req, inst_addr);
    end
  endtask

  task automatic test_reset_midflight();
    inst_addr_ok = 1'b1; tick();
    inst_data_ok = 1'b1; stall = 1'b1; inst_rdata = 64'h9999_9999_9999_9999; tick();
    rst = 1'b1; stall = 1'b1; tick();
    stall = 1'b1; #1;
    checks++;
    if ({pc, inst_req, inst_rdata_1_ok, inst_rdata_2_ok, inst_rdata_1} !== {32'hBFC0_0000, 35'd0}) begin
      errors++; $display("FAIL rst_hold got pc=%h req=%b ok=%b%b d1=%h want bfc00000 0 00 0",
        pc, inst_req, inst_rdata_1_ok, inst_rdata_2_ok, inst_rdata_1);
    end
    tick();
    checks++;
    if (inst_req !== 1'b1) begin errors++; $display("FAIL rst_hold_req got %b want 1", inst_req); end
    inst_addr_ok = 1'b1; redirect = 1'b1; next_pc = 32'h8000_0400; tick();
    rst = 1'b1; tick();
    checks++;
    if ({pc, inst_req, inst_rdata_1_ok, inst_rdata_2_ok} !== {32'hBFC0_0000, 3'b000}) begin
      errors++; $display("FAIL rst_cancel got pc=%h req=%b ok=%b%b want bfc00000 000",
        pc, inst_req, inst_rdata_1_ok, inst_rdata_2_ok);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_two_word();
    test_one_word();
    test_hold();
    test_cancel();
    test_redirect_collide();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
